// File: rtl/fetch_unit.sv
// fetch_unit: PC, in-order I-cache requests, 2-entry fetch queue, redirect flush.
// Optional macro FETCH_MISALIGN_TRAP_EN: a misaligned redirect sets sticky misalign and halts fetch.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        req_valid,
    output logic [31:0] req_addr,
    input  logic        req_ready,
    input  logic        resp_valid,
    input  logic [31:0] resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    output logic        misalign
);
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [1:0]  occ_q, occ_d;
    logic [1:0]  inflight_q, inflight_d;
    logic [1:0]  drop_q, drop_d;
    logic        hd_q, hd_d;
    logic        af_hd_q, af_hd_d;
    logic        mis_q, mis_d;
    logic [31:0] q_data_q  [2];
    logic [31:0] q_pc_q    [2];
    logic [31:0] af_addr_q [2];

    logic        redir;
    logic        accept;
    logic        resp_take;
    logic        push;
    logic        pop;
    logic        misaligned_redir;
    logic        q_tail;
    logic        af_tail;
    logic [2:0]  credit_used;

    // Credit covers both queued words and outstanding requests, so a push never finds the queue full.
    assign credit_used = {1'b0, occ_q} + {1'b0, inflight_q};
    assign redir       = redirect_valid && (state_q != HALT);
    assign req_valid   = (state_q == RUN) && !redirect_valid && (credit_used < 3'd2);
    assign req_addr    = pc_q;
    assign accept      = req_valid && req_ready;

    assign resp_take   = resp_valid && (inflight_q != 2'd0);
    assign push        = resp_take && !redir && (drop_q == 2'd0) && (state_q != HALT);

    assign instr_valid = (occ_q != 2'd0);
    assign pop         = instr_valid && instr_ready && !redir;
    assign instr       = q_data_q[hd_q];
    assign instr_pc    = q_pc_q[hd_q];
    assign misalign    = mis_q;

    // With one entry held, the tail is the other slot; otherwise tail and head coincide.
    assign q_tail      = hd_q ^ (occ_q == 2'd1);
    assign af_tail     = af_hd_q ^ (inflight_q == 2'd1);

`ifdef FETCH_MISALIGN_TRAP_EN
    assign misaligned_redir = redir && (redirect_pc[1:0] != 2'b00);
`else
    assign misaligned_redir = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        occ_d      = occ_q;
        inflight_d = inflight_q;
        drop_d     = drop_q;
        hd_d       = hd_q;
        af_hd_d    = af_hd_q;
        mis_d      = mis_q;

        case (state_q)
            BOOT:    state_d = RUN;
            RUN:     state_d = RUN;
            HALT:    state_d = HALT;
            default: state_d = BOOT;
        endcase

        if (misaligned_redir) begin
            state_d = HALT;
            mis_d   = 1'b1;
        end

        if (accept) begin
            pc_d = pc_q + 32'd4;
        end
        if (pop) begin
            hd_d = ~hd_q;
        end
        if (resp_take) begin
            af_hd_d = ~af_hd_q;
        end
        if (resp_take && (drop_q != 2'd0)) begin
            drop_d = drop_q - 2'd1;
        end

        inflight_d = inflight_q + {1'b0, accept} - {1'b0, resp_take};
        occ_d      = occ_q + {1'b0, push} - {1'b0, pop};

        // Everything still outstanding after this edge belongs to the old path.
        if (redir) begin
            pc_d   = redirect_pc & 32'hFFFF_FFFC;
            occ_d  = 2'd0;
            drop_d = inflight_q - {1'b0, resp_take};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC;
            occ_q      <= 2'd0;
            inflight_q <= 2'd0;
            drop_q     <= 2'd0;
            hd_q       <= 1'b0;
            af_hd_q    <= 1'b0;
            mis_q      <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                q_data_q[i]  <= NOP;
                q_pc_q[i]    <= 32'h0;
                af_addr_q[i] <= 32'h0;
            end
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
            hd_q       <= hd_d;
            af_hd_q    <= af_hd_d;
            mis_q      <= mis_d;
            if (push) begin
                q_data_q[q_tail] <= resp_data;
                q_pc_q[q_tail]   <= af_addr_q[af_hd_q];
            end
            if (accept) begin
                af_addr_q[af_tail] <= pc_q;
            end
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: queue-based reference model, in-order cache model and directed phases.
`timescale 1ns/1ps
module tb_fetch_unit;
    localparam logic [31:0] RST_PC = 32'hBFC0_0000;
    localparam logic [31:0] KEY    = 32'hDEAD_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        misalign;
    logic        resp_en;

    int checks   = 0;
    int failures = 0;

    fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_data(resp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
        .instr_ready(instr_ready), .misalign(misalign)
    );

    initial forever #5 clk = ~clk;

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b t=%0t", nm, act, exp, $time);
        end
    endtask

    // Cache: answers in request order, never in the acceptance cycle; data = addr ^ KEY.
    logic [31:0] cq[$];
    logic        acc_s = 1'b0;
    logic [31:0] acc_addr = 32'h0;
    initial begin
        resp_valid = 1'b0;
        resp_data  = 32'h0;
        forever begin
            @(negedge clk);
            #1;
            resp_valid = resp_en && (cq.size() != 0);
            resp_data  = (cq.size() != 0) ? (cq[0] ^ KEY) : 32'h0;
            acc_s      = req_valid && req_ready;
            acc_addr   = req_addr;
        end
    end
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            cq.delete();
        end else begin
            if (resp_valid) void'(cq.pop_front());
            if (acc_s) cq.push_back(acc_addr);
        end
    end

    // Reference model: outstanding requests and queued words as plain lists.
    typedef struct { logic [31:0] a; bit stale; } inf_t;
    typedef struct { logic [31:0] d; logic [31:0] a; } fq_t;
    inf_t        m_inf[$];
    fq_t         m_fq[$];
    int          m_st  = 0;  // 0 boot, 1 run, 2 halt
    logic [31:0] m_pc  = RST_PC;
    logic        m_mis = 1'b0;

    function automatic logic m_req();
        return (m_st == 1) && !redirect_valid && ((m_fq.size() + m_inf.size()) < 2);
    endfunction

    task automatic model_step();
        logic acc;
        logic red;
        inf_t e;
        fq_t  f;
        acc = m_req() && req_ready;
        red = redirect_valid && (m_st != 2);
        if (m_st == 0) m_st = 1;
        if ((m_fq.size() != 0) && instr_ready && !red) void'(m_fq.pop_front());
        if (resp_valid && (m_inf.size() != 0)) begin
            e = m_inf.pop_front();
            if (!e.stale && !red && (m_st != 2)) begin
                f.d = resp_data;
                f.a = e.a;
                m_fq.push_back(f);
            end
        end
        if (acc) begin
            e.a = m_pc;
            e.stale = 1'b0;
            m_inf.push_back(e);
            m_pc = m_pc + 32'd4;
        end
        if (red) begin
            m_fq.delete();
            foreach (m_inf[i]) m_inf[i].stale = 1'b1;
            m_pc = {redirect_pc[31:2], 2'b00};
`ifdef FETCH_MISALIGN_TRAP_EN
            if (redirect_pc[1:0] != 2'b00) begin
                m_st  = 2;
                m_mis = 1'b1;
            end
`endif
        end
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_inf.delete();
            m_fq.delete();
            m_st  = 0;
            m_pc  = RST_PC;
            m_mis = 1'b0;
        end else begin
            model_step();
        end
    end

    // Per-cycle comparison against the model.
    initial forever begin
        @(negedge clk);
        #2;
        chk1("req_valid", req_valid, m_req());
        if (m_req()) chk32("req_addr", req_addr, m_pc);
        chk1("instr_valid", instr_valid, m_fq.size() != 0);
        if (m_fq.size() != 0) begin
            chk32("instr", instr, m_fq[0].d);
            chk32("instr_pc", instr_pc, m_fq[0].a);
        end
        chk1("misalign", misalign, m_mis);
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        req_ready = 1'b1;
        instr_ready = 1'b1;
        resp_en = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        req_ready = 1'b1;
        instr_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        resp_en = 1'b1;
        repeat (2) @(negedge clk);
        #3;
        chk1("rst_req_valid", req_valid, 1'b0);
        chk32("rst_req_addr", req_addr, RST_PC);
        chk1("rst_instr_valid", instr_valid, 1'b0);
        chk32("rst_instr", instr, 32'h0000_0013);
        chk32("rst_instr_pc", instr_pc, 32'h0);
        chk1("rst_misalign", misalign, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Free run with a 1-cycle cache.
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            #3;
            if (c == 1) begin
                chk1("a_c1_req_valid", req_valid, 1'b1);
                chk32("a_c1_req_addr", req_addr, RST_PC);
            end
            if (c == 2) begin
                chk32("a_c2_req_addr", req_addr, RST_PC + 32'd4);
                chk1("a_c2_instr_valid", instr_valid, 1'b0);
            end
            if (c == 3) begin
                chk1("a_c3_instr_valid", instr_valid, 1'b1);
                chk32("a_c3_instr_pc", instr_pc, RST_PC);
                chk32("a_c3_instr", instr, 32'h616D_0000);
            end
        end

        // Decode stall fills the queue, then release.
        do_reset();
        instr_ready = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 7) instr_ready = 1'b1;
            #3;
            if (c == 6) begin
                chk1("b_c6_req_valid", req_valid, 1'b0);
                chk1("b_c6_instr_valid", instr_valid, 1'b1);
                chk32("b_c6_instr_pc", instr_pc, RST_PC);
            end
            if (c == 8) begin
                chk1("b_c8_req_valid", req_valid, 1'b1);
                chk32("b_c8_req_addr", req_addr, RST_PC + 32'd8);
                chk32("b_c8_instr_pc", instr_pc, RST_PC + 32'd4);
            end
        end

        // Redirect with two in flight, one answering in the redirect cycle.
        do_reset();
        resp_en = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 4) begin
                resp_en = 1'b1;
                redirect_valid = 1'b1;
                redirect_pc = 32'h0000_0100;
            end
            if (c == 5) redirect_valid = 1'b0;
            #3;
            if (c == 3) chk1("c_c3_req_valid", req_valid, 1'b0);
            if (c == 5) begin
                chk1("c_c5_req_valid", req_valid, 1'b1);
                chk32("c_c5_req_addr", req_addr, 32'h0000_0100);
                chk1("c_c5_instr_valid", instr_valid, 1'b0);
            end
            if (c == 6) chk1("c_c6_instr_valid", instr_valid, 1'b0);
            if (c == 7) begin
                chk1("c_c7_instr_valid", instr_valid, 1'b1);
                chk32("c_c7_instr_pc", instr_pc, 32'h0000_0100);
                chk32("c_c7_instr", instr, 32'hDEAD_0100);
            end
        end

        // Cache back-pressure for 5 cycles.
        do_reset();
        req_ready = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 6) req_ready = 1'b1;
            #3;
            if (c == 5) begin
                chk1("d_c5_req_valid", req_valid, 1'b1);
                chk32("d_c5_req_addr", req_addr, RST_PC);
                chk1("d_c5_instr_valid", instr_valid, 1'b0);
            end
            if (c == 8) begin
                chk1("d_c8_instr_valid", instr_valid, 1'b1);
                chk32("d_c8_instr_pc", instr_pc, RST_PC);
            end
        end

        // PC wrap after redirect to the top word.
        do_reset();
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 3) begin
                redirect_valid = 1'b1;
                redirect_pc = 32'hFFFF_FFFC;
            end
            if (c == 4) redirect_valid = 1'b0;
            #3;
            if (c == 4) begin
                chk1("e_c4_req_valid", req_valid, 1'b1);
                chk32("e_c4_req_addr", req_addr, 32'hFFFF_FFFC);
            end
            if (c == 5) begin
                chk1("e_c5_req_valid", req_valid, 1'b1);
                chk32("e_c5_req_addr", req_addr, 32'h0000_0000);
            end
            if (c == 6) begin
                chk32("e_c6_instr_pc", instr_pc, 32'hFFFF_FFFC);
                chk32("e_c6_instr", instr, 32'h2152_FFFC);
            end
        end

        // Back-to-back redirects: the later target wins.
        do_reset();
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 3) begin
                redirect_valid = 1'b1;
                redirect_pc = 32'h0000_0200;
            end
            if (c == 4) redirect_pc = 32'h0000_0300;
            if (c == 5) redirect_valid = 1'b0;
            #3;
            if (c == 5) chk32("g_c5_req_addr", req_addr, 32'h0000_0300);
            if (c == 7) chk32("g_c7_instr_pc", instr_pc, 32'h0000_0300);
        end

        // Misaligned redirect.
        do_reset();
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 3) begin
                redirect_valid = 1'b1;
                redirect_pc = 32'h0000_0102;
            end
            if (c == 4) redirect_valid = 1'b0;
            #3;
`ifdef FETCH_MISALIGN_TRAP_EN
            if (c == 6) begin
                chk1("f_c6_misalign", misalign, 1'b1);
                chk1("f_c6_req_valid", req_valid, 1'b0);
                chk1("f_c6_instr_valid", instr_valid, 1'b0);
            end
`else
            if (c == 4) begin
                chk1("f_c4_req_valid", req_valid, 1'b1);
                chk32("f_c4_req_addr", req_addr, 32'h0000_0100);
                chk1("f_c4_misalign", misalign, 1'b0);
            end
`endif
        end

        // Reset recovers from any prior state.
        do_reset();
        @(negedge clk);
        #3;
        chk1("h_c1_misalign", misalign, 1'b0);
        chk1("h_c1_req_valid", req_valid, 1'b1);
        chk32("h_c1_req_addr", req_addr, RST_PC);
        repeat (3) @(negedge clk);
        #3;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
